// File: rtl/mem_drv_pkg.sv
// Shared constants and types for the memory driver's SIPO capture path.
package mem_drv_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned FRAME_W   = NUM_LANES * CNT_W;
    localparam int unsigned IDX_W     = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

endpackage

// File: rtl/event_counter.sv
// One wrapping event counter lane; a clear that coincides with an event restarts at 1.
module event_counter #(
    parameter int unsigned CNT_W = mem_drv_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr_load,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Event in the clear cycle belongs to the new interval
    always_comb begin
        cnt_d = cnt_q;
        if (clr_load) begin
            cnt_d = CNT_W'(inc);
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/count_serializer.sv
// Four event counters snapshotted on capture and sent MSB-first as a 32-bit serial frame.
module count_serializer #(
    parameter int unsigned NUM_LANES = mem_drv_pkg::NUM_LANES,
    parameter int unsigned CNT_W     = mem_drv_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] event_in,
    input  logic                 capture,
    output logic                 si,
    output logic                 validin,
    output logic [7:0]           shift,
    output logic                 busy,
    output logic                 done,
    output logic                 pending
);

    import mem_drv_pkg::ser_state_t;
    import mem_drv_pkg::IDLE;
    import mem_drv_pkg::SHIFT;
    import mem_drv_pkg::DONE;

    localparam int unsigned FRAME_W = NUM_LANES * CNT_W;
    localparam int unsigned IDX_W   = $clog2(FRAME_W);
    localparam int unsigned SHIFT_W = 8;

    ser_state_t          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FRAME_W-1:0]  snap_q, snap_d;
    logic                pending_q, pending_d;
    logic                si_q, si_d;
    logic                validin_q, validin_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept_c;
    logic [FRAME_W-1:0]  cnt_flat;

    // Lane i occupies byte i of the flat vector, so lane NUM_LANES-1 is the MSB
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        event_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (event_in[i]),
            .clr_load (accept_c),
            .cnt      (cnt_flat[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        pending_d = pending_q;
        accept_c  = 1'b0;
        si_d      = 1'b0;
        validin_d = 1'b0;
        shift_d   = '0;
        done_d    = 1'b0;
        busy_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (capture || pending_q) begin
                    accept_c  = 1'b1;
                    snap_d    = cnt_flat;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                si_d      = snap_q[IDX_W'(FRAME_W - 1) - idx_q];
                validin_d = 1'b1;
                shift_d   = SHIFT_W'(idx_q);
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(FRAME_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // One capture may queue behind the active frame; extras are dropped
        if (capture && (state_q != IDLE) && !pending_q) begin
            pending_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            pending_q <= 1'b0;
            si_q      <= 1'b0;
            validin_q <= 1'b0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            si_q      <= si_d;
            validin_q <= validin_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign si      = si_q;
    assign validin = validin_q;
    assign shift   = shift_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pending = pending_q;

endmodule
